// File: rtl/alu_loader_pkg.sv
// Shared definitions for the ALU operand loader: FSM phases, result word layout
// and the default debounce length.
package alu_loader_pkg;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        EXEC    = 2'd3
    } phase_e;

    localparam int RES_P      = 7;
    localparam int RES_V      = 6;
    localparam int RES_C      = 5;
    localparam int RES_Z      = 4;
    localparam int RES_OUT_HI = 3;
    localparam int RES_OUT_LO = 0;

    typedef struct packed {
        logic       p;
        logic       v;
        logic       c;
        logic       z;
        logic [3:0] out;
    } res_t;

    localparam int DEBOUNCE_CYCLES_DEF = 16;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioning: 2-FF synchronizer, consecutive-cycle debounce counter
// and rising-edge detect producing a one-cycle press pulse.
module btn_debounce
    import alu_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press,
    output logic level
);

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic        sync1, sync2;
    logic        level_prev;
    logic [15:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            level_prev <= 1'b0;
            cnt        <= '0;
        end else begin
            sync1      <= btn_raw;
            sync2      <= sync1;
            level_prev <= level;
            // any agreeing cycle restarts the count, so bounces never accumulate
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    assign press = level & ~level_prev;

endmodule

// File: rtl/alu_operand_loader.sv
// Nibble-serial operand entry for the 4-bit ALU: A, B, opcode loaded on debounced
// presses, one EXEC cycle, then the ALU result word is held for display.
module alu_operand_loader
    import alu_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic [3:0] nib_in,
    input  logic [7:0] alu_res,
    output logic [3:0] opd_a,
    output logic [3:0] opd_b,
    output logic [3:0] opcode,
    output logic       op_valid,
    output logic [7:0] res_q,
    output logic       res_valid,
    output logic [1:0] phase
);

    phase_e state;
    res_t   res_r;
    logic   press;
    logic   level_unused;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw),
        .press  (press),
        .level  (level_unused)
    );

    // op_valid is registered alongside the EXEC transition so it is glitch-free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD_A;
            opd_a     <= '0;
            opd_b     <= '0;
            opcode    <= '0;
            res_r     <= '0;
            res_valid <= 1'b0;
            op_valid  <= 1'b0;
        end else begin
            op_valid <= 1'b0;
            case (state)
                LOAD_A: if (press) begin
                    opd_a     <= nib_in;
                    res_valid <= 1'b0;
                    state     <= LOAD_B;
                end
                LOAD_B: if (press) begin
                    opd_b <= nib_in;
                    state <= LOAD_OP;
                end
                LOAD_OP: if (press) begin
                    opcode   <= nib_in;
                    op_valid <= 1'b1;
                    state    <= EXEC;
                end
                EXEC: begin
                    res_r     <= res_t'(alu_res);
                    res_valid <= 1'b1;
                    state     <= LOAD_A;
                end
                default: state <= LOAD_A;
            endcase
        end
    end

    assign res_q = res_r;
    assign phase = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a small add-with-flags ALU model.
module tb_alu_operand_loader;

    localparam int D = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_raw;
    logic [3:0] nib_in;
    logic [7:0] alu_res;
    logic [3:0] opd_a, opd_b, opcode;
    logic       op_valid;
    logic [7:0] res_q;
    logic       res_valid;
    logic [1:0] phase;

    int n_chk  = 0;
    int n_fail = 0;
    int ov_cnt = 0;
    int ov_base;

    logic [4:0] sum;

    alu_operand_loader #(.DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .nib_in   (nib_in),
        .alu_res  (alu_res),
        .opd_a    (opd_a),
        .opd_b    (opd_b),
        .opcode   (opcode),
        .op_valid (op_valid),
        .res_q    (res_q),
        .res_valid(res_valid),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    // ALU model: A+B with {parity, signed overflow, carry, zero, sum}
    always_comb begin
        sum     = {1'b0, opd_a} + {1'b0, opd_b};
        alu_res = {^sum[3:0], (opd_a[3] == opd_b[3]) && (sum[3] != opd_a[3]),
                   sum[4], sum[3:0] == 4'd0, sum[3:0]};
    end

    always @(negedge clk) if (op_valid) ov_cnt <= ov_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Clean rising edge; checks phase is unchanged just before edge k+2+D and advanced after it.
    task automatic do_press(input logic [3:0] nib, input string tag);
        logic [1:0] p0;
        @(negedge clk);
        nib_in  = nib;
        btn_raw = 1'b1;
        p0      = phase;
        repeat (D + 2) @(posedge clk);
        @(negedge clk);
        chk({tag, "_pre"}, 32'(phase), 32'(p0));
        @(negedge clk);
        chk({tag, "_cap"}, 32'(phase), 32'(p0 + 2'd1));
        nib_in = ~nib;
    endtask

    task automatic release_btn(input int bounces);
        for (int i = 0; i < bounces; i++) begin
            @(negedge clk) btn_raw = 1'b0;
            repeat (3) @(negedge clk);
            btn_raw = 1'b1;
            repeat (2) @(negedge clk);
        end
        @(negedge clk) btn_raw = 1'b0;
        repeat (D + 4) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; btn_raw = 1'b0; nib_in = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_phase", 32'(phase), 32'd0);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("idle_phase", 32'(phase), 32'd0);
        chk("idle_opds", {20'd0, opd_a, opd_b, opcode}, 32'd0);
        chk("idle_res", {23'd0, res_valid, res_q}, 32'd0);
        chk("idle_ov", 32'(ov_cnt), 32'd0);

        // first operation: A clean, B bouncy, glitch, opcode with long hold
        do_press(4'h6, "a1");
        chk("a1_val", 32'(opd_a), 32'h6);
        release_btn(0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) btn_raw = 1'b1;
            repeat (2) @(negedge clk);
            btn_raw = 1'b0;
            repeat (2) @(negedge clk);
        end
        chk("bounce_nocap", 32'(phase), 32'd1);
        do_press(4'h2, "b1");
        chk("b1_val", 32'(opd_b), 32'h2);
        release_btn(0);
        @(negedge clk) btn_raw = 1'b1;
        repeat (10) @(negedge clk);
        btn_raw = 1'b0;
        repeat (30) @(negedge clk);
        chk("glitch_nocap", 32'(phase), 32'd2);

        ov_base = ov_cnt;
        do_press(4'h4, "op1");
        chk("ex1_ov", 32'(op_valid), 32'd1);
        chk("ex1_opds", {20'd0, opd_a, opd_b, opcode}, 32'h624);
        @(negedge clk);
        chk("ex1_ov_off", 32'(op_valid), 32'd0);
        chk("ex1_res", 32'(res_q), 32'hC8);
        chk("ex1_rv", 32'(res_valid), 32'd1);
        chk("ex1_phase", 32'(phase), 32'd0);
        repeat (200 - D - 4) @(negedge clk);
        chk("hold_phase", 32'(phase), 32'd0);
        release_btn(5);
        chk("rel_phase", 32'(phase), 32'd0);
        chk("ex1_ov_once", 32'(ov_cnt - ov_base), 32'd1);

        // second operation
        do_press(4'hF, "a2");
        chk("a2_val", 32'(opd_a), 32'hF);
        chk("a2_rv", 32'(res_valid), 32'd0);
        chk("a2_res", 32'(res_q), 32'hC8);
        release_btn(0);
        do_press(4'h1, "b2");
        release_btn(0);
        chk("b2_res", 32'(res_q), 32'hC8);
        do_press(4'h4, "op2");
        chk("ex2_res_old", 32'(res_q), 32'hC8);
        @(negedge clk);
        chk("ex2_res", 32'(res_q), 32'h30);
        chk("ex2_rv", 32'(res_valid), 32'd1);
        release_btn(0);

        // reset mid-entry
        do_press(4'h6, "a3");
        release_btn(0);
        do_press(4'h2, "b3");
        release_btn(0);
        chk("pre_rst_phase", 32'(phase), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_phase", 32'(phase), 32'd0);
        chk("mid_rst_opds", {20'd0, opd_a, opd_b, opcode}, 32'd0);
        chk("mid_rst_res", {23'd0, res_valid, res_q}, 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_phase", 32'(phase), 32'd0);
        do_press(4'h1, "a4");
        release_btn(0);
        do_press(4'h2, "b4");
        release_btn(0);
        do_press(4'h4, "op4");
        chk("ex4_opds", {20'd0, opd_a, opd_b, opcode}, 32'h124);
        @(negedge clk);
        chk("ex4_res", 32'(res_q), 32'h03);
        chk("ex4_rv", 32'(res_valid), 32'd1);
        release_btn(0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
